// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared types and constants for the snake move unit: grid
//                geometry, direction encoding, movement verdict codes and
//                the move-unit state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package snake_pkg;

  localparam int DEF_GRID_W  = 32;
  localparam int DEF_GRID_H  = 24;
  localparam int DEF_MAX_LEN = 64;
  localparam int DEF_X_W     = 5;
  localparam int DEF_Y_W     = 5;
  localparam int DEF_LEN_W   = 7;

  localparam int INIT_LEN    = 3;
  localparam int INIT_HEAD_X = DEF_GRID_W / 2;
  localparam int INIT_HEAD_Y = DEF_GRID_H / 2;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  localparam logic [1:0] MV_NONE = 2'b00;
  localparam logic [1:0] MV_STEP = 2'b01;
  localparam logic [1:0] MV_EAT  = 2'b10;
  localparam logic [1:0] MV_DEAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_SCAN    = 3'd2,
    S_COMMIT  = 3'd3,
    S_REPORT  = 3'd4,
    S_WAITLOW = 3'd5
  } state_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic isReversal(input dir_t cur, input logic [1:0] req);
    return req == (cur ^ 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_body_ring.sv
`default_nettype none
// ============================================================================
//  Module      : snake_body_ring
//  Description : Circular store of snake segment coordinates. Segment i
//                (0 = head) lives at headPtr - i modulo MAX_LEN. Provides a
//                head write port, one indexed read port and a tail read port.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_body_ring import snake_pkg::*; #(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int INIT_X  = INIT_HEAD_X,
  parameter int INIT_Y  = INIT_HEAD_Y
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             push,
  input  logic             grow,
  input  logic [X_W-1:0]   wrX,
  input  logic [Y_W-1:0]   wrY,
  input  logic [LEN_W-1:0] rdIdx,
  output logic [X_W-1:0]   rdX,
  output logic [Y_W-1:0]   rdY,
  output logic [X_W-1:0]   headX,
  output logic [Y_W-1:0]   headY,
  output logic [X_W-1:0]   tailX,
  output logic [Y_W-1:0]   tailY,
  output logic [LEN_W-1:0] len
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [X_W-1:0]   r_memX [MAX_LEN];
  logic [Y_W-1:0]   r_memY [MAX_LEN];
  logic [PTR_W-1:0] r_headPtr;
  logic [LEN_W-1:0] r_len;
  logic [PTR_W-1:0] w_rdPtr;
  logic [PTR_W-1:0] w_tailPtr;
  logic [PTR_W-1:0] w_nextPtr;

  function automatic logic [PTR_W-1:0] ptrBack(input logic [PTR_W-1:0] p,
                                               input logic [LEN_W-1:0] n);
    int unsigned t;
    t = (32'(p) + 32'(MAX_LEN) - (32'(n) % 32'(MAX_LEN))) % 32'(MAX_LEN);
    return PTR_W'(t);
  endfunction

  function automatic logic [PTR_W-1:0] ptrFwd(input logic [PTR_W-1:0] p);
    int unsigned t;
    t = (32'(p) + 32'd1) % 32'(MAX_LEN);
    return PTR_W'(t);
  endfunction

  // Initial snake occupies slots 0..INIT_LEN-1, oldest (leftmost) first.
  function automatic logic [X_W-1:0] initSegX(input int i);
    return (i < INIT_LEN) ? X_W'(INIT_X - (INIT_LEN - 1 - i)) : '0;
  endfunction

  function automatic logic [Y_W-1:0] initSegY(input int i);
    return (i < INIT_LEN) ? Y_W'(INIT_Y) : '0;
  endfunction

  // Pointer arithmetic for the read, tail and next-head slots.
  always_comb begin
    w_rdPtr   = ptrBack(r_headPtr, rdIdx);
    w_tailPtr = ptrBack(r_headPtr, r_len - LEN_W'(1));
    w_nextPtr = ptrFwd(r_headPtr);
  end

  // Ring storage: initial snake load has priority over a head push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_memX[i] <= initSegX(i);
        r_memY[i] <= initSegY(i);
      end
      r_headPtr <= PTR_W'(INIT_LEN - 1);
      r_len     <= LEN_W'(INIT_LEN);
    end else if (init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_memX[i] <= initSegX(i);
        r_memY[i] <= initSegY(i);
      end
      r_headPtr <= PTR_W'(INIT_LEN - 1);
      r_len     <= LEN_W'(INIT_LEN);
    end else if (push) begin
      r_memX[w_nextPtr] <= wrX;
      r_memY[w_nextPtr] <= wrY;
      r_headPtr         <= w_nextPtr;
      if (grow && (r_len < LEN_W'(MAX_LEN))) begin
        r_len <= r_len + LEN_W'(1);
      end
    end
  end

  assign rdX   = r_memX[w_rdPtr];
  assign rdY   = r_memY[w_rdPtr];
  assign headX = r_memX[r_headPtr];
  assign headY = r_memY[r_headPtr];
  assign tailX = r_memX[w_tailPtr];
  assign tailY = r_memY[w_tailPtr];
  assign len   = r_len;

endmodule
`default_nettype wire

// File: rtl/snake_move_unit.sv
`default_nettype none
// ============================================================================
//  Module      : snake_move_unit
//  Description : Performs one snake step per moveGo request: wall check,
//                sequential self-collision scan, food check, body update,
//                and a one-cycle step/eat/die verdict for the game FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_move_unit import snake_pkg::*; #(
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             setUpGo,
  input  logic             moveGo,
  input  logic [1:0]       dirIn,
  input  logic             dirValid,
  input  logic [X_W-1:0]   foodX,
  input  logic [Y_W-1:0]   foodY,
  output logic [1:0]       movementLogic,
  output logic [X_W-1:0]   headX,
  output logic [Y_W-1:0]   headY,
  output logic [X_W-1:0]   tailX,
  output logic [Y_W-1:0]   tailY,
  output logic             tailClr,
  output logic [LEN_W-1:0] snakeLen
);

  state_t           r_state;
  dir_t             r_curDir;
  dir_t             r_pendDir;
  logic [X_W-1:0]   r_nx;
  logic [Y_W-1:0]   r_ny;
  logic             r_grow;
  logic [LEN_W-1:0] r_k;
  logic [LEN_W-1:0] r_scanIdx;
  logic [1:0]       r_move;
  logic [X_W-1:0]   r_tailX;
  logic [Y_W-1:0]   r_tailY;
  logic             r_tailClr;

  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  logic             w_wall;
  logic             w_grow;
  logic [LEN_W-1:0] w_kNext;
  logic [X_W-1:0]   w_segX;
  logic [Y_W-1:0]   w_segY;
  logic [X_W-1:0]   w_ringTailX;
  logic [Y_W-1:0]   w_ringTailY;
  logic             w_hit;
  logic             w_commit;
  logic             w_ringGrow;

  snake_body_ring #(
    .MAX_LEN (MAX_LEN),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .LEN_W   (LEN_W),
    .INIT_X  (GRID_W / 2),
    .INIT_Y  (GRID_H / 2)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .init  (setUpGo),
    .push  (w_commit),
    .grow  (w_ringGrow),
    .wrX   (r_nx),
    .wrY   (r_ny),
    .rdIdx (r_scanIdx),
    .rdX   (w_segX),
    .rdY   (w_segY),
    .headX (headX),
    .headY (headY),
    .tailX (w_ringTailX),
    .tailY (w_ringTailY),
    .len   (snakeLen)
  );

  // Next head cell from the pending direction, flagging a wall hit.
  always_comb begin
    w_nx   = headX;
    w_ny   = headY;
    w_wall = 1'b0;
    unique case (r_pendDir)
      UP:      if (headY == '0) w_wall = 1'b1; else w_ny = headY - Y_W'(1);
      RIGHT:   if (headX == X_W'(GRID_W - 1)) w_wall = 1'b1; else w_nx = headX + X_W'(1);
      DOWN:    if (headY == Y_W'(GRID_H - 1)) w_wall = 1'b1; else w_ny = headY + Y_W'(1);
      default: if (headX == '0) w_wall = 1'b1; else w_nx = headX - X_W'(1);
    endcase
    w_grow  = (w_nx == foodX) && (w_ny == foodY);
    // The tail cell is vacated by a plain step, so it is not scanned then.
    w_kNext = w_grow ? snakeLen : snakeLen - LEN_W'(1);
  end

  // Scan compare and commit strobe; the final clean compare commits directly
  // so REPORT follows the scan without an extra cycle.
  always_comb begin
    w_hit      = (r_state == S_SCAN) && (w_segX == r_nx) && (w_segY == r_ny);
    w_commit   = !setUpGo &&
                 (((r_state == S_SCAN) && !w_hit && (r_scanIdx == r_k - LEN_W'(1))) ||
                  (r_state == S_COMMIT));
    w_ringGrow = r_grow && (snakeLen < LEN_W'(MAX_LEN));
  end

  // Move-unit FSM with registered verdict, tail cell and direction latching.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_curDir  <= RIGHT;
      r_pendDir <= RIGHT;
      r_nx      <= '0;
      r_ny      <= '0;
      r_grow    <= 1'b0;
      r_k       <= '0;
      r_scanIdx <= '0;
      r_move    <= MV_NONE;
      r_tailX   <= '0;
      r_tailY   <= '0;
      r_tailClr <= 1'b0;
    end else if (setUpGo) begin
      r_state   <= S_IDLE;
      r_curDir  <= RIGHT;
      r_pendDir <= RIGHT;
      r_nx      <= '0;
      r_ny      <= '0;
      r_grow    <= 1'b0;
      r_k       <= '0;
      r_scanIdx <= '0;
      r_move    <= MV_NONE;
      r_tailX   <= '0;
      r_tailY   <= '0;
      r_tailClr <= 1'b0;
    end else begin
      r_move    <= MV_NONE;
      r_tailClr <= 1'b0;
      if (dirValid && !isReversal(r_curDir, dirIn)) begin
        r_pendDir <= dir_t'(dirIn);
      end
      if (w_commit) begin
        r_move <= r_grow ? MV_EAT : MV_STEP;
        if (!w_ringGrow) begin
          r_tailX   <= w_ringTailX;
          r_tailY   <= w_ringTailY;
          r_tailClr <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (moveGo) r_state <= S_CALC;
        end
        S_CALC: begin
          r_curDir  <= r_pendDir;
          r_nx      <= w_nx;
          r_ny      <= w_ny;
          r_grow    <= w_grow;
          r_k       <= w_kNext;
          r_scanIdx <= '0;
          if (w_wall) begin
            r_move  <= MV_DEAD;
            r_state <= S_REPORT;
          end else if (w_kNext == '0) begin
            r_state <= S_COMMIT;
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_move  <= MV_DEAD;
            r_state <= S_REPORT;
          end else if (w_commit) begin
            r_state <= S_REPORT;
          end else begin
            r_scanIdx <= r_scanIdx + LEN_W'(1);
          end
        end
        S_COMMIT:  r_state <= S_REPORT;
        S_REPORT:  r_state <= S_WAITLOW;
        S_WAITLOW: if (!moveGo) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign movementLogic = r_move;
  assign tailX         = r_tailX;
  assign tailY         = r_tailY;
  assign tailClr       = r_tailClr;

endmodule
`default_nettype wire

// File: tb/tb_snake_move_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_snake_move_unit
//  Description : Scoreboard bench for snake_move_unit. A list-based snake
//                model predicts each move's verdict, latency and resulting
//                cells; predictions are queued and popped on the verdict.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snake_move_unit;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int MAX_LEN = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       setUpGo = 1'b0;
  logic       moveGo = 1'b0;
  logic [1:0] dirIn = 2'b00;
  logic       dirValid = 1'b0;
  logic [4:0] foodX = 5'd0;
  logic [4:0] foodY = 5'd0;
  logic [1:0] movementLogic;
  logic [4:0] headX, headY, tailX, tailY;
  logic       tailClr;
  logic [6:0] snakeLen;

  snake_move_unit dut (
    .clk           (clk),
    .reset         (reset),
    .setUpGo       (setUpGo),
    .moveGo        (moveGo),
    .dirIn         (dirIn),
    .dirValid      (dirValid),
    .foodX         (foodX),
    .foodY         (foodY),
    .movementLogic (movementLogic),
    .headX         (headX),
    .headY         (headY),
    .tailX         (tailX),
    .tailY         (tailY),
    .tailClr       (tailClr),
    .snakeLen      (snakeLen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int lat; int hx; int hy; int tx; int ty; int clr; int len;
  } exp_t;

  exp_t sb[$];
  int   mX[$];
  int   mY[$];
  int   mDir, mPend, mTx, mTy;
  int   nTests = 0;
  int   nFail  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelInit();
    mX = {16, 15, 14};
    mY = {12, 12, 12};
    mDir = 1; mPend = 1; mTx = 0; mTy = 0;
  endtask

  task automatic predictMove();
    exp_t e;
    int nx, ny, k, len, firstHit;
    bit wall, grow;
    mDir = mPend;
    nx = mX[0]; ny = mY[0]; wall = 0;
    case (mDir)
      0:       if (ny == 0) wall = 1; else ny--;
      1:       if (nx == GRID_W - 1) wall = 1; else nx++;
      2:       if (ny == GRID_H - 1) wall = 1; else ny++;
      default: if (nx == 0) wall = 1; else nx--;
    endcase
    len = mX.size();
    e.clr = 0;
    if (wall) begin
      e.res = 3; e.lat = 1;
    end else begin
      grow = (nx == int'(foodX)) && (ny == int'(foodY));
      k = grow ? len : len - 1;
      firstHit = -1;
      for (int i = 0; i < k; i++)
        if (firstHit < 0 && mX[i] == nx && mY[i] == ny) firstHit = i;
      if (firstHit >= 0) begin
        e.res = 3; e.lat = 2 + firstHit;
      end else begin
        e.lat = 1 + k;
        mX.push_front(nx); mY.push_front(ny);
        if (grow && len < MAX_LEN) begin
          e.res = 2;
        end else begin
          mTx = mX.pop_back(); mTy = mY.pop_back();
          e.clr = 1;
          e.res = grow ? 2 : 1;
        end
      end
    end
    e.hx = mX[0]; e.hy = mY[0]; e.tx = mTx; e.ty = mTy; e.len = mX.size();
    sb.push_back(e);
  endtask

  task automatic strobeDir(input int d);
    @(negedge clk);
    dirIn = 2'(d); dirValid = 1'b1;
    if (d != (mDir ^ 2)) mPend = d;
    @(negedge clk);
    dirValid = 1'b0;
  endtask

  task automatic doMove(input string tag);
    exp_t e;
    int n;
    bit seen;
    predictMove();
    @(negedge clk);
    moveGo = 1'b1;
    @(posedge clk);
    n = 0; seen = 0;
    while (n < 200 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (movementLogic != 2'b00) seen = 1;
    end
    e = sb.pop_front();
    checkVal($sformatf("%s.seen", tag), 32'(seen), 32'd1);
    checkVal($sformatf("%s.res", tag), 32'(movementLogic), e.res);
    checkVal($sformatf("%s.lat", tag), n, e.lat);
    checkVal($sformatf("%s.headX", tag), 32'(headX), e.hx);
    checkVal($sformatf("%s.headY", tag), 32'(headY), e.hy);
    checkVal($sformatf("%s.tailX", tag), 32'(tailX), e.tx);
    checkVal($sformatf("%s.tailY", tag), 32'(tailY), e.ty);
    checkVal($sformatf("%s.tailClr", tag), 32'(tailClr), e.clr);
    checkVal($sformatf("%s.len", tag), 32'(snakeLen), e.len);
    repeat (3) @(posedge clk);
    #1;
    checkVal($sformatf("%s.heldMv", tag), 32'(movementLogic), 32'd0);
    checkVal($sformatf("%s.heldHeadX", tag), 32'(headX), e.hx);
    checkVal($sformatf("%s.heldHeadY", tag), 32'(headY), e.hy);
    @(negedge clk);
    moveGo = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic checkInit(input string tag);
    checkVal($sformatf("%s.mv", tag), 32'(movementLogic), 32'd0);
    checkVal($sformatf("%s.headX", tag), 32'(headX), 32'd16);
    checkVal($sformatf("%s.headY", tag), 32'(headY), 32'd12);
    checkVal($sformatf("%s.tailX", tag), 32'(tailX), 32'd0);
    checkVal($sformatf("%s.tailY", tag), 32'(tailY), 32'd0);
    checkVal($sformatf("%s.tailClr", tag), 32'(tailClr), 32'd0);
    checkVal($sformatf("%s.len", tag), 32'(snakeLen), 32'd3);
  endtask

  task automatic doReset();
    reset = 1'b0; moveGo = 1'b0; setUpGo = 1'b0; dirValid = 1'b0;
    foodX = 5'd0; foodY = 5'd0;
    modelInit();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic growToFive();
    doReset();
    foodX = 5'd17; foodY = 5'd12; doMove("grow1");
    foodX = 5'd18; foodY = 5'd12; doMove("grow2");
    foodX = 5'd0;  foodY = 5'd0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: sim time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state and a plain step right
    doReset();
    checkInit("t1rst");
    doMove("t1step");

    // 2: reversal strobe is dropped
    doReset();
    strobeDir(3);
    doMove("t2rev");

    // 3: eat, then up/left/down into the vacating tail cell
    doReset();
    foodX = 5'd17; foodY = 5'd12;
    doMove("t3eat");
    foodX = 5'd0; foodY = 5'd0;
    strobeDir(0); doMove("t3up");
    strobeDir(3); doMove("t3left");
    strobeDir(2); doMove("t3down");

    // 4: length 5, self collision on the third turn
    growToFive();
    strobeDir(0); doMove("t4up");
    strobeDir(3); doMove("t4left");
    strobeDir(2); doMove("t4self");

    // 5: run up into the top wall
    doReset();
    strobeDir(0);
    for (int i = 0; i < 12; i++) doMove($sformatf("t5up%0d", i));
    doMove("t5wall");

    // 6a: asynchronous reset during the body scan
    growToFive();
    @(negedge clk); moveGo = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0; moveGo = 1'b0;
    modelInit();
    #1;
    checkInit("t6rst");
    @(negedge clk); reset = 1'b1;

    // 6b: setUpGo during the body scan
    growToFive();
    @(negedge clk); moveGo = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    setUpGo = 1'b1; moveGo = 1'b0;
    modelInit();
    @(posedge clk); #1;
    checkInit("t6setup");
    @(negedge clk); setUpGo = 1'b0;
    doMove("t6after");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
